// File: rtl/flash_arb_pkg.sv
// Shared widths and owner encoding for the two-port flash read arbiter.
package flash_arb_pkg;
    localparam int FLASH_AW = 16;
    localparam int FLASH_DW = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P0   = 2'd1,
        P1   = 2'd2
    } owner_t;
endpackage

// File: rtl/flash_tag_pipe.sv
// Shift register carrying {valid, port} for each issued read until its data returns.
module flash_tag_pipe
    import flash_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_valid,
    input  logic i_port,
    output logic o_valid,
    output logic o_port
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_port;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= '0;
            r_port  <= '0;
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], i_valid};
            r_port  <= {r_port[DEPTH-2:0], i_port};
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_port  = r_port[DEPTH-1];

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one pipelined flash read port
// between the weight fetcher (port 0) and the image loader (port 1).
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int FLASH_LATENCY = 2,
    parameter int MAX_BURST     = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                req0,
    input  logic [FLASH_AW-1:0] addr0,
    output logic                gnt0,
    output logic                rvalid0,
    input  logic                req1,
    input  logic [FLASH_AW-1:0] addr1,
    output logic                gnt1,
    output logic                rvalid1,
    output logic [FLASH_DW-1:0] rdata,
    input  logic                flash_busy,
    output logic                flash_rd,
    output logic [FLASH_AW-1:0] flash_addr,
    input  logic [FLASH_DW-1:0] flash_data
);

    localparam int            BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);
    localparam logic [BW-1:0] ONE  = BW'(1);

    owner_t              r_owner, w_owner_nxt;
    owner_t              r_last, w_last_nxt;
    logic [BW-1:0]       r_bcnt, w_bcnt_nxt;
    logic                w_gnt0, w_gnt1;
    logic                w_tag_valid, w_tag_port;
    logic                r_flash_rd;
    logic [FLASH_AW-1:0] r_flash_addr;
    logic                r_rvalid0, r_rvalid1;
    logic [FLASH_DW-1:0] r_rdata;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_owner <= NONE;
            r_last  <= P1;
            r_bcnt  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    // An owner that drops its request or exhausts its burst hands over in the same cycle.
    always_comb begin
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_bcnt_nxt  = r_bcnt;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        if (!flash_busy) begin
            case (r_owner)
                P0: begin
                    if (req0 && (r_bcnt < MAXB || !req1)) begin
                        w_gnt0     = 1'b1;
                        w_bcnt_nxt = (r_bcnt < MAXB) ? r_bcnt + 1'b1 : MAXB;
                    end else begin
                        w_last_nxt = P0;
                        if (req1) begin
                            w_gnt1      = 1'b1;
                            w_owner_nxt = P1;
                            w_bcnt_nxt  = ONE;
                        end else begin
                            w_owner_nxt = NONE;
                        end
                    end
                end
                P1: begin
                    if (req1 && (r_bcnt < MAXB || !req0)) begin
                        w_gnt1     = 1'b1;
                        w_bcnt_nxt = (r_bcnt < MAXB) ? r_bcnt + 1'b1 : MAXB;
                    end else begin
                        w_last_nxt = P1;
                        if (req0) begin
                            w_gnt0      = 1'b1;
                            w_owner_nxt = P0;
                            w_bcnt_nxt  = ONE;
                        end else begin
                            w_owner_nxt = NONE;
                        end
                    end
                end
                default: begin
                    if (req0 && (!req1 || r_last != P0)) begin
                        w_gnt0      = 1'b1;
                        w_owner_nxt = P0;
                        w_bcnt_nxt  = ONE;
                    end else if (req1) begin
                        w_gnt1      = 1'b1;
                        w_owner_nxt = P1;
                        w_bcnt_nxt  = ONE;
                    end
                end
            endcase
        end
    end

    flash_tag_pipe #(
        .DEPTH(FLASH_LATENCY + 1)
    ) u_tag_pipe (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_valid(w_gnt0 | w_gnt1),
        .i_port (w_gnt1),
        .o_valid(w_tag_valid),
        .o_port (w_tag_port)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_flash_rd   <= 1'b0;
            r_flash_addr <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_flash_rd <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
                r_flash_addr <= addr0;
            end else if (w_gnt1) begin
                r_flash_addr <= addr1;
            end
            r_rvalid0 <= w_tag_valid & ~w_tag_port;
            r_rvalid1 <= w_tag_valid & w_tag_port;
            if (w_tag_valid) begin
                r_rdata <= flash_data;
            end
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign flash_rd   = r_flash_rd;
    assign flash_addr = r_flash_addr;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;
    assign rdata      = r_rdata;

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Shares the single weight/image flash read port between two requesters: the network controller's weight fetch (port 0) and the pixel image loader (port 1). Round-robin arbitration with bounded bursts, one read issued per cycle, fixed-latency pipelined returns routed back to the requester that issued each read. Sits between both requesters and the flash model/controller.

## Interface
Parameters:
- FLASH_LATENCY, 2: cycles from `flash_rd` high to `flash_data` valid (1..8).
- MAX_BURST, 4: consecutive grants an owner keeps while the other port is waiting (1..15).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low.
- req0  in  1  port 0 (weights) read request; held with addr0 until granted.
- addr0  in  16  port 0 read address.
- gnt0  out  1  port 0 accept; a read transfers on an edge where req0 && gnt0.
- rvalid0  out  1  one-cycle pulse: rdata belongs to port 0.
- req1, addr1, gnt1, rvalid1: same as port 0, for the image loader.
- rdata  out  16  returned flash word, shared by both ports.
- flash_busy  in  1  flash cannot accept a read this cycle.
- flash_rd  out  1  registered read strobe.
- flash_addr  out  16  registered read address.
- flash_data  in  16  flash read data.

## Operation
- State: `owner` (NONE, P0, P1) plus burst counter `bcnt` (width $clog2(MAX_BURST+1)), plus `last` (last served port, reset P1 so port 0 wins first).
- No grants while flash_busy = 1; state and bcnt hold.
- NONE: only one req high -> grant it, owner <= that port, bcnt <= 1. Both high -> grant the port != last. Neither -> stay.
- Owner Px with reqx high:
  - bcnt < MAX_BURST, or other port idle -> grant x, bcnt increments, saturating at MAX_BURST when the other port is idle.
  - bcnt == MAX_BURST and other port requesting -> grant other port that same cycle, owner <= other, bcnt <= 1, last <= x.
- Owner Px with reqx low: behave as NONE with last <= x (other port granted same cycle if requesting, else owner <= NONE).
- gnt0 and gnt1 are never high together. Grants are combinational from req/state; gnt is 0 when the matching req is 0.
- Each granted read pushes {valid, port} into a tag pipeline of depth FLASH_LATENCY+1. A tag exiting the pipe drives rvalid of its port with rdata <= flash_data (registered).
- Reads are strictly in order; no backpressure on returns (requesters must always accept rvalid).
- Reset mid-operation: tag pipe cleared, in-flight reads discarded (no rvalid after reset release), owner <= NONE, last <= P1.

## Timing
- Reset values: gnt0/gnt1 combinational (0 with reqs low), rvalid0 = rvalid1 = 0, rdata = 0, flash_rd = 0, flash_addr = 0.
- Grant at edge T -> flash_rd = 1 and flash_addr = granted address during cycle T+1.
- flash_data sampled FLASH_LATENCY cycles after the flash_rd cycle -> rvalid/rdata high one cycle later. Total grant-to-rvalid = FLASH_LATENCY+2 cycles (4 by default).
- Throughput is 1 read per cycle sustained. Arbitration switch costs no bubble.
- flash_rd is low in any cycle following an edge with no grant. flash_addr holds its last value.

## Structure
- Package `flash_arb_pkg`: FLASH_AW = 16, FLASH_DW = 16, and the owner_t enum (NONE, P0, P1).
- Sub-module `flash_tag_pipe`: parameterised-depth shift register of {valid, port, …} with async clear. Instantiated once.
- Arbitration FSM and output registers live in `flash_arbiter`.

## Test plan
- Reset then single read: req0, addr0 = 0x0010, flash returns 0xBEEF -> gnt0 in cycle 0, flash_rd/addr 0x0010 in cycle 1, rvalid0 with rdata 0xBEEF at cycle 4, rvalid1 never high.
- Simultaneous first request: req0 and req1 high from reset -> port 0 granted first. After MAX_BURST = 4 grants, port 1 gets 4 grants with no bubble, then alternation continues in 4-grant bursts.
- Lone requester: req1 held for 20 cycles with req0 low -> 20 back-to-back grants. Returns arrive in order with addresses incrementing and data matching.
- flash_busy high for 3 cycles mid-burst -> no grants and flash_rd low for those cycles. bcnt preserved, so the burst resumes and the total per-burst grants still equal 4.
- Interleaved returns: alternate ports with MAX_BURST = 1 -> rvalid0/rvalid1 alternate each cycle, each carrying data for its own address.
- Reset asserted with 3 reads in flight -> outputs return to their reset values immediately. No rvalid after release. The first post-reset grant goes to port 0.
